// File: rtl/lc3_ctrl_pkg.sv
// rtl/lc3_ctrl_pkg.sv - LC-3 control state codes, opcodes, mux encodings and state decode
package lc3_ctrl_pkg;

    typedef enum logic [5:0] {
        S0  = 6'd0,  S1  = 6'd1,  S2  = 6'd2,  S3  = 6'd3,  S4  = 6'd4,
        S5  = 6'd5,  S6  = 6'd6,  S7  = 6'd7,  S9  = 6'd9,  S10 = 6'd10,
        S11 = 6'd11, S12 = 6'd12, S14 = 6'd14, S15 = 6'd15, S16 = 6'd16,
        S18 = 6'd18, S20 = 6'd20, S21 = 6'd21, S22 = 6'd22, S23 = 6'd23,
        S24 = 6'd24, S25 = 6'd25, S26 = 6'd26, S27 = 6'd27, S28 = 6'd28,
        S29 = 6'd29, S30 = 6'd30, S31 = 6'd31, S32 = 6'd32, S33 = 6'd33,
        S35 = 6'd35, S47 = 6'd47
    } state_t;

    localparam logic [3:0] OP_BR  = 4'd0,  OP_ADD = 4'd1,  OP_LD   = 4'd2,  OP_ST  = 4'd3;
    localparam logic [3:0] OP_JSR = 4'd4,  OP_AND = 4'd5,  OP_LDR  = 4'd6,  OP_STR = 4'd7;
    localparam logic [3:0] OP_RTI = 4'd8,  OP_NOT = 4'd9,  OP_LDI  = 4'd10, OP_STI = 4'd11;
    localparam logic [3:0] OP_JMP = 4'd12, OP_RSV = 4'd13, OP_LEA  = 4'd14, OP_TRAP = 4'd15;

    localparam logic       MARMUX_ZEXT  = 1'b0, MARMUX_ADDER = 1'b1;
    localparam logic       ADDR1_PC     = 1'b0, ADDR1_SR1    = 1'b1;
    localparam logic [1:0] ADDR2_ZERO   = 2'd0, ADDR2_OFF6   = 2'd1, ADDR2_OFF9 = 2'd2, ADDR2_OFF11 = 2'd3;
    localparam logic [1:0] PCMUX_INC    = 2'd0, PCMUX_BUS    = 2'd1, PCMUX_ADDER = 2'd2;
    localparam logic [1:0] SR1_IR11_9   = 2'd0, SR1_IR8_6    = 2'd1, SR1_R6 = 2'd2;
    localparam logic [1:0] DR_IR11_9    = 2'd0, DR_R7        = 2'd1, DR_R6  = 2'd2;
    localparam logic [1:0] ALUK_ADD     = 2'd0, ALUK_AND     = 2'd1, ALUK_NOT = 2'd2, ALUK_PASSA = 2'd3;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_pc;
        logic       ld_reg;
        logic       ld_cc;
        logic       ld_ben;
        logic       gate_marmux;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_pc;
        logic       marmux;
        logic       addr1;
        logic [1:0] addr2;
        logic [1:0] pcmux;
        logic [1:0] sr1mux;
        logic [1:0] drmux;
        logic       cs;
        logic       we;
        logic [1:0] aluk;
    } ctrl_t;

    function automatic state_t dispatch(input logic [3:0] op);
        case (op)
            OP_BR:   return S0;
            OP_ADD:  return S1;
            OP_LD:   return S2;
            OP_ST:   return S3;
            OP_JSR:  return S4;
            OP_AND:  return S5;
            OP_LDR:  return S6;
            OP_STR:  return S7;
            OP_NOT:  return S9;
            OP_LDI:  return S10;
            OP_STI:  return S11;
            OP_JMP:  return S12;
            OP_LEA:  return S14;
            OP_TRAP: return S15;
            OP_RTI, OP_RSV: return S18;
            default: return S18;
        endcase
    endfunction

    // Every field not set for a state stays 0, which is also the reset value.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S18: begin c.gate_pc = 1'b1; c.ld_mar = 1'b1; c.ld_pc = 1'b1; c.pcmux = PCMUX_INC; end
            S33, S25, S24, S29, S28: begin c.cs = 1'b1; c.ld_mdr = 1'b1; end
            S35: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
            S32: c.ld_ben = 1'b1;
            S1, S5, S9: begin
                c.gate_alu = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1;
                c.sr1mux = SR1_IR8_6; c.drmux = DR_IR11_9;
                c.aluk = (s == S1) ? ALUK_ADD : (s == S5) ? ALUK_AND : ALUK_NOT;
            end
            S22: begin c.ld_pc = 1'b1; c.pcmux = PCMUX_ADDER; c.addr1 = ADDR1_PC; c.addr2 = ADDR2_OFF9; end
            S2, S3, S10, S11: begin
                c.gate_marmux = 1'b1; c.marmux = MARMUX_ADDER; c.ld_mar = 1'b1;
                c.addr1 = ADDR1_PC; c.addr2 = ADDR2_OFF9;
            end
            S6, S7: begin
                c.gate_marmux = 1'b1; c.marmux = MARMUX_ADDER; c.ld_mar = 1'b1;
                c.addr1 = ADDR1_SR1; c.addr2 = ADDR2_OFF6; c.sr1mux = SR1_IR8_6;
            end
            S27: begin c.gate_mdr = 1'b1; c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.drmux = DR_IR11_9; end
            S26, S31: begin c.gate_mdr = 1'b1; c.ld_mar = 1'b1; end
            S23: begin
                c.gate_alu = 1'b1; c.aluk = ALUK_PASSA; c.sr1mux = SR1_IR11_9;
                c.ld_mdr = 1'b1; c.cs = 1'b0;
            end
            S16: begin c.cs = 1'b1; c.we = 1'b1; end
            S14: begin
                c.gate_marmux = 1'b1; c.marmux = MARMUX_ADDER; c.addr1 = ADDR1_PC; c.addr2 = ADDR2_OFF9;
                c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.drmux = DR_IR11_9;
            end
            S4, S15: begin c.gate_pc = 1'b1; c.ld_reg = 1'b1; c.drmux = DR_R7; end
            S21: begin c.ld_pc = 1'b1; c.pcmux = PCMUX_ADDER; c.addr1 = ADDR1_PC; c.addr2 = ADDR2_OFF11; end
            S20, S12: begin
                c.ld_pc = 1'b1; c.pcmux = PCMUX_ADDER; c.addr1 = ADDR1_SR1;
                c.addr2 = ADDR2_ZERO; c.sr1mux = SR1_IR8_6;
            end
            S47: begin c.gate_marmux = 1'b1; c.marmux = MARMUX_ZEXT; c.ld_mar = 1'b1; end
            S30: begin c.gate_mdr = 1'b1; c.ld_pc = 1'b1; c.pcmux = PCMUX_BUS; end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lc3_control_unit_cc_ben.sv
// rtl/lc3_control_unit_cc_ben.sv - N/Z/P condition codes and branch-enable register
module lc3_cc_ben (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_bus,
    input  logic [2:0]  i_ir_nzp,
    input  logic        i_ld_cc,
    input  logic        i_ld_ben,
    output logic        o_n,
    output logic        o_z,
    output logic        o_p,
    output logic        o_ben
);
    logic r_n, r_z, r_p, r_ben;
    logic w_zero;

    assign w_zero = (i_bus == 16'h0000);

    // BEN samples the codes as registered before this edge, not the ones loaded on it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_n   <= 1'b0;
            r_z   <= 1'b1;
            r_p   <= 1'b0;
            r_ben <= 1'b0;
        end else begin
            if (i_ld_cc) begin
                r_n <= i_bus[15];
                r_z <= w_zero;
                r_p <= !i_bus[15] && !w_zero;
            end
            if (i_ld_ben)
                r_ben <= |(i_ir_nzp & {r_n, r_z, r_p});
        end
    end

    assign o_n   = r_n;
    assign o_z   = r_z;
    assign o_p   = r_p;
    assign o_ben = r_ben;
endmodule

// File: rtl/lc3_control_unit.sv
// rtl/lc3_control_unit.sv - LC-3 microsequencer with registered Moore control outputs
module lc3_control_unit
    import lc3_ctrl_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] BUS,
    input  logic [15:0] IR,
    input  logic        READY,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_PC,
    output logic        LD_REG,
    output logic        LD_CC,
    output logic        LD_BEN,
    output logic        GateMARMUX,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GatePC,
    output logic        MARMUXsel,
    output logic        ADDR1MUXsel,
    output logic [1:0]  ADDR2MUXsel,
    output logic [1:0]  PCMUXsel,
    output logic [1:0]  SR1MUXsel,
    output logic [1:0]  DRMUXsel,
    output logic        CS,
    output logic        WE,
    output logic [1:0]  ALUK,
    output logic        N,
    output logic        Z,
    output logic        P,
    output logic        BEN
);
    state_t r_state, w_next;
    ctrl_t  r_ctrl, w_ctrl;
    logic   w_ben;

    always_comb begin
        w_next = S18;
        case (r_state)
            S18: w_next = S33;
            S33: w_next = READY ? S35 : S33;
            S35: w_next = S32;
            S32: w_next = dispatch(IR[15:12]);
            S0:  w_next = w_ben ? S22 : S18;
            S2, S6: w_next = S25;
            S25: w_next = READY ? S27 : S25;
            S10: w_next = S24;
            S24: w_next = READY ? S26 : S24;
            S26: w_next = S25;
            S3, S7: w_next = S23;
            S23: w_next = S16;
            S16: w_next = READY ? S18 : S16;
            S11: w_next = S29;
            S29: w_next = READY ? S31 : S29;
            S31: w_next = S23;
            S4:  w_next = IR[11] ? S21 : S20;
            S15: w_next = S47;
            S47: w_next = S28;
            S28: w_next = READY ? S30 : S28;
            default: w_next = S18;
        endcase
    end

    // Outputs are registered as the decode of the state being entered, so they line up with r_state.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S18;
            r_ctrl  <= decode(S18);
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode(w_next);
        end
    end

    assign w_ctrl = RST ? r_ctrl : '0;

    lc3_cc_ben u_cc_ben (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_bus    (BUS),
        .i_ir_nzp (IR[11:9]),
        .i_ld_cc  (w_ctrl.ld_cc),
        .i_ld_ben (w_ctrl.ld_ben),
        .o_n      (N),
        .o_z      (Z),
        .o_p      (P),
        .o_ben    (w_ben)
    );

    assign BEN         = w_ben;
    assign LD_MAR      = w_ctrl.ld_mar;
    assign LD_MDR      = w_ctrl.ld_mdr;
    assign LD_IR       = w_ctrl.ld_ir;
    assign LD_PC       = w_ctrl.ld_pc;
    assign LD_REG      = w_ctrl.ld_reg;
    assign LD_CC       = w_ctrl.ld_cc;
    assign LD_BEN      = w_ctrl.ld_ben;
    assign GateMARMUX  = w_ctrl.gate_marmux;
    assign GateMDR     = w_ctrl.gate_mdr;
    assign GateALU     = w_ctrl.gate_alu;
    assign GatePC      = w_ctrl.gate_pc;
    assign MARMUXsel   = w_ctrl.marmux;
    assign ADDR1MUXsel = w_ctrl.addr1;
    assign ADDR2MUXsel = w_ctrl.addr2;
    assign PCMUXsel    = w_ctrl.pcmux;
    assign SR1MUXsel   = w_ctrl.sr1mux;
    assign DRMUXsel    = w_ctrl.drmux;
    assign CS          = w_ctrl.cs;
    assign WE          = w_ctrl.we;
    assign ALUK        = w_ctrl.aluk;
endmodule

// File: tb/tb_lc3_control_unit.sv
// tb/tb_lc3_control_unit.sv - self-checking bench for lc3_control_unit
module tb_lc3_control_unit;
    logic        CLK = 1'b0;
    logic        RST, READY;
    logic [15:0] BUS, IR;
    logic LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN;
    logic GateMARMUX, GateMDR, GateALU, GatePC, MARMUXsel, ADDR1MUXsel, CS, WE;
    logic [1:0] ADDR2MUXsel, PCMUXsel, SR1MUXsel, DRMUXsel, ALUK;
    logic N, Z, P, BEN;

    lc3_control_unit dut (
        .CLK(CLK), .RST(RST), .BUS(BUS), .IR(IR), .READY(READY),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_PC(LD_PC), .LD_REG(LD_REG),
        .LD_CC(LD_CC), .LD_BEN(LD_BEN), .GateMARMUX(GateMARMUX), .GateMDR(GateMDR),
        .GateALU(GateALU), .GatePC(GatePC), .MARMUXsel(MARMUXsel), .ADDR1MUXsel(ADDR1MUXsel),
        .ADDR2MUXsel(ADDR2MUXsel), .PCMUXsel(PCMUXsel), .SR1MUXsel(SR1MUXsel),
        .DRMUXsel(DRMUXsel), .CS(CS), .WE(WE), .ALUK(ALUK), .N(N), .Z(Z), .P(P), .BEN(BEN)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_pc, ld_reg, ld_cc, ld_ben;
        logic g_marmux, g_mdr, g_alu, g_pc, marmux, addr1;
        logic [1:0] addr2, pcmux, sr1mux, drmux;
        logic cs, we;
        logic [1:0] aluk;
    } tcw_t;

    tcw_t act;
    assign act = {LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN,
                  GateMARMUX, GateMDR, GateALU, GatePC, MARMUXsel, ADDR1MUXsel,
                  ADDR2MUXsel, PCMUXsel, SR1MUXsel, DRMUXsel, CS, WE, ALUK};

    int n_chk = 0;
    int n_err = 0;
    logic m_n, m_z, m_p, m_ben;

    // Expected control word for each microstate, written from the state table.
    function automatic tcw_t cw_of(input int s);
        tcw_t c = '0;
        case (s)
            18: begin c.g_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
            33, 25, 24, 29, 28: begin c.cs = 1; c.ld_mdr = 1; end
            35: begin c.g_mdr = 1; c.ld_ir = 1; end
            32: c.ld_ben = 1;
            1, 5, 9: begin
                c.g_alu = 1; c.ld_reg = 1; c.ld_cc = 1; c.sr1mux = 2'd1;
                c.aluk = (s == 1) ? 2'd0 : (s == 5) ? 2'd1 : 2'd2;
            end
            22: begin c.ld_pc = 1; c.pcmux = 2'd2; c.addr2 = 2'd2; end
            2, 3, 10, 11: begin c.g_marmux = 1; c.marmux = 1; c.ld_mar = 1; c.addr2 = 2'd2; end
            6, 7: begin
                c.g_marmux = 1; c.marmux = 1; c.ld_mar = 1;
                c.addr1 = 1; c.addr2 = 2'd1; c.sr1mux = 2'd1;
            end
            27: begin c.g_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
            26, 31: begin c.g_mdr = 1; c.ld_mar = 1; end
            23: begin c.g_alu = 1; c.aluk = 2'd3; c.ld_mdr = 1; end
            16: begin c.cs = 1; c.we = 1; end
            14: begin c.g_marmux = 1; c.marmux = 1; c.addr2 = 2'd2; c.ld_reg = 1; c.ld_cc = 1; end
            4, 15: begin c.g_pc = 1; c.ld_reg = 1; c.drmux = 2'd1; end
            21: begin c.ld_pc = 1; c.pcmux = 2'd2; c.addr2 = 2'd3; end
            20, 12: begin c.ld_pc = 1; c.pcmux = 2'd2; c.addr1 = 1; c.sr1mux = 2'd1; end
            47: begin c.g_marmux = 1; c.ld_mar = 1; end
            30: begin c.g_mdr = 1; c.ld_pc = 1; c.pcmux = 2'd1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic bit is_mem(input int s);
        return (s == 33 || s == 25 || s == 24 || s == 29 || s == 28 || s == 16);
    endfunction

    function automatic logic [15:0] rbus();
        case ($urandom_range(3, 0))
            0: return 16'h0000;
            1: return 16'h8000 | 16'($urandom);
            default: return 16'($urandom);
        endcase
    endfunction

    // One cycle in state s: drive, check, clock, then advance the CC/BEN model.
    task automatic step(input int s, input logic rdy, input logic [15:0] bus);
        tcw_t e;
        e = cw_of(s);
        READY = rdy;
        BUS = bus;
        #1;
        n_chk++;
        if (act !== e) begin
            n_err++;
            $display("FAIL cw S%0d: got %h want %h", s, act, e);
        end
        n_chk++;
        if ({N, Z, P, BEN} !== {m_n, m_z, m_p, m_ben}) begin
            n_err++;
            $display("FAIL nzpb S%0d: got %b want %b", s, {N, Z, P, BEN}, {m_n, m_z, m_p, m_ben});
        end
        n_chk++;
        if ($countones({GateMARMUX, GateMDR, GateALU, GatePC}) > 1) begin
            n_err++;
            $display("FAIL gates S%0d: got %b want at most one", s, {GateMARMUX, GateMDR, GateALU, GatePC});
        end
        @(posedge CLK);
        if (e.ld_cc) begin
            m_n = bus[15];
            m_z = (bus == 16'h0);
            m_p = !m_n && !m_z;
        end
        if (s == 32)
            m_ben = (IR[11] & m_n) | (IR[10] & m_z) | (IR[9] & m_p);
        @(negedge CLK);
    endtask

    task automatic run_instr(input logic [15:0] ir, input bit fixb, input logic [15:0] fbus,
                             input int smin, input int smax);
        int path[$];
        bit b;
        IR = ir;
        b = (ir[11] & m_n) | (ir[10] & m_z) | (ir[9] & m_p);
        path = '{18, 33, 35, 32};
        case (ir[15:12])
            4'd0:  begin path.push_back(0); if (b) path.push_back(22); end
            4'd1:  path.push_back(1);
            4'd5:  path.push_back(5);
            4'd9:  path.push_back(9);
            4'd2:  path = {path, 2, 25, 27};
            4'd6:  path = {path, 6, 25, 27};
            4'd10: path = {path, 10, 24, 26, 25, 27};
            4'd3:  path = {path, 3, 23, 16};
            4'd7:  path = {path, 7, 23, 16};
            4'd11: path = {path, 11, 29, 31, 23, 16};
            4'd14: path.push_back(14);
            4'd4:  path = {path, 4, (ir[11] ? 21 : 20)};
            4'd12: path.push_back(12);
            4'd15: path = {path, 15, 47, 28, 30};
            default: ;
        endcase
        foreach (path[k]) begin
            logic [15:0] bv;
            bv = fixb ? fbus : rbus();
            if (is_mem(path[k])) begin
                repeat ($urandom_range(smax, smin)) step(path[k], 1'b0, bv);
                step(path[k], 1'b1, bv);
            end else begin
                step(path[k], 1'($urandom), bv);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_chk++;
        if (act !== '0) begin
            n_err++;
            $display("FAIL %s outputs: got %h want 0", tag, act);
        end
    endtask

    typedef struct {
        logic [15:0] ir;
        logic [15:0] bus;
        logic [2:0]  nzp;
        logic        ben;
    } vec_t;

    initial begin
        vec_t tbl[8];
        tbl[0] = '{16'h1261, 16'h8000, 3'b100, 1'b0};
        tbl[1] = '{16'h1261, 16'h0000, 3'b010, 1'b0};
        tbl[2] = '{16'h1261, 16'h0005, 3'b001, 1'b0};
        tbl[3] = '{16'h1261, 16'h0000, 3'b010, 1'b1};
        tbl[4] = '{16'h0403, 16'h1234, 3'b010, 1'b1};
        tbl[5] = '{16'h0803, 16'h1234, 3'b010, 1'b0};
        tbl[6] = '{16'hA005, 16'hFFFF, 3'b100, 1'b0};
        tbl[7] = '{16'hF025, 16'h0042, 3'b100, 1'b0};

        RST = 1'b0; READY = 1'b0; BUS = 16'h0; IR = 16'h0;
        repeat (2) begin
            @(negedge CLK);
            check_reset_outputs("reset");
        end
        n_chk++;
        if ({N, Z, P, BEN} !== 4'b0100) begin
            n_err++;
            $display("FAIL reset nzpb: got %b want 0100", {N, Z, P, BEN});
        end
        m_n = 0; m_z = 1; m_p = 0; m_ben = 0;
        RST = 1'b1;

        // Directed vectors; three-cycle READY stall on every memory access including fetch.
        for (int i = 0; i < 8; i++) begin
            run_instr(tbl[i].ir, 1'b1, tbl[i].bus, 3, 3);
            n_chk++;
            if ({N, Z, P, BEN} !== {tbl[i].nzp, tbl[i].ben}) begin
                n_err++;
                $display("FAIL vec%0d ir=%h: got %b want %b", i, tbl[i].ir, {N, Z, P, BEN}, {tbl[i].nzp, tbl[i].ben});
            end
        end

        for (int i = 0; i < 60; i++)
            run_instr(16'($urandom), 1'b0, 16'h0, 0, 2);

        // Reset asserted during a fetch READY stall abandons the access.
        step(18, 1'b1, 16'h8000);
        step(33, 1'b0, 16'h8000);
        step(33, 1'b0, 16'h8000);
        RST = 1'b0;
        #1 check_reset_outputs("midreset_async");
        @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("midreset");
        n_chk++;
        if ({N, Z, P, BEN} !== 4'b0100) begin
            n_err++;
            $display("FAIL midreset nzpb: got %b want 0100", {N, Z, P, BEN});
        end
        m_n = 0; m_z = 1; m_p = 0; m_ben = 0;
        RST = 1'b1;
        run_instr(16'h5020, 1'b1, 16'h0007, 1, 1);
        step(18, 1'b0, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lc3_control_unit.md
Name: lc3_control_unit

Overview:
- LC-3 datapath control block: microsequencer FSM, condition-code (N/Z/P) register and branch-enable (BEN) register in one unit.
- Observes the shared 16-bit BUS, the IR and the memory READY flag.
- Drives every load, gate, mux-select, ALU and memory-control signal of the single-bus LC-3 datapath.
- Moore-style: control outputs decode from current state only.

Parameters:
- None. State codes, opcodes and mux encodings are package constants.

Ports:
- CLK in 1: rising-edge clock.
- RST in 1: synchronous, active-low reset.
- BUS in 16: shared datapath bus (CC source).
- IR in 16: instruction register contents.
- READY in 1: memory access complete.
- LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN out 1: register load enables.
- GateMARMUX, GateMDR, GateALU, GatePC out 1: bus tristate enables.
- MARMUXsel out 1: 0 = ZEXT(IR[7:0]), 1 = adder.
- ADDR1MUXsel out 1: 0 = PC, 1 = SR1.
- ADDR2MUXsel out 2: 0 = zero, 1 = SEXT off6, 2 = off9, 3 = off11.
- PCMUXsel out 2: 0 = PC+1, 1 = BUS, 2 = adder.
- SR1MUXsel out 2: 0 = IR[11:9], 1 = IR[8:6], 2 = R6.
- DRMUXsel out 2: 0 = IR[11:9], 1 = R7, 2 = R6.
- CS out 1: memory select; also MDR input selects RAM.
- WE out 1: memory write.
- ALUK out 2: 00 ADD, 01 AND, 10 NOT, 11 PASSA.
- N, Z, P out 1: condition codes.
- BEN out 1: branch enable.

Behaviour:
- Reset: on a rising CLK edge with RST=0:
  - state <= S18.
  - N=0, Z=1, P=0, BEN=0.
- While RST=0, all control outputs are forced to 0.
- Any output not listed for a state is 0; unlisted selects are 0.
- CC update: on an edge with LD_CC=1:
  - N = BUS[15].
  - Z = (BUS == 0).
  - P = !N && !Z.
  - Exactly one of N, Z, P is set after any load.
- BEN update: on an edge with LD_BEN=1, BEN <= (IR[11]&N) | (IR[10]&Z) | (IR[9]&P), using the current registered N, Z, P.
- Memory states:
  - Read: CS=1, WE=0, LD_MDR=1.
  - Write: CS=1, WE=1.
  - Both hold until READY=1, then advance on that edge.
  - READY is ignored in all other states.
- Fetch sequence:
  - S18: GatePC, LD_MAR, LD_PC, PCMUX=0 -> S33.
  - S33: read -> S35.
  - S35: GateMDR, LD_IR -> S32.
  - S32: LD_BEN -> dispatch on IR[15:12].
- Dispatch targets:
  - 0 (BR) -> S0.
  - 1 (ADD) -> S1.
  - 5 (AND) -> S5.
  - 9 (NOT) -> S9.
  - 2 (LD) -> S2.
  - 6 (LDR) -> S6.
  - 10 (LDI) -> S10.
  - 3 (ST) -> S3.
  - 7 (STR) -> S7.
  - 11 (STI) -> S11.
  - 14 (LEA) -> S14.
  - 4 (JSR) -> S4.
  - 12 (JMP) -> S12.
  - 15 (TRAP) -> S15.
  - 8 (RTI) and 13 (reserved): no-op, -> S18.
- ALU ops (all assert GateALU, LD_REG, LD_CC, SR1MUX=1, DRMUX=0, then -> S18):
  - S1: ALUK=00.
  - S5: ALUK=01.
  - S9: ALUK=10.
- Branch:
  - S0: BEN=1 -> S22, else -> S18.
  - S22: LD_PC, PCMUX=2, ADDR1=0, ADDR2=2 -> S18.
- Address-calc states (GateMARMUX, MARMUX=1, LD_MAR):
  - S2, S3, S10, S11: ADDR1=0, ADDR2=2.
  - S6, S7: ADDR1=1, ADDR2=1, SR1MUX=1.
- Loads:
  - S2, S6 -> S25 (read) -> S27.
  - S27: GateMDR, LD_REG, LD_CC, DRMUX=0 -> S18.
  - S10 -> S24 (read) -> S26.
  - S26: GateMDR, LD_MAR -> S25.
- Stores:
  - S3, S7 -> S23.
  - S23: GateALU, ALUK=11, SR1MUX=0, LD_MDR, CS=0 -> S16.
  - S16: write -> S18.
  - S11 -> S29 (read) -> S31.
  - S31: GateMDR, LD_MAR -> S23.
- LEA:
  - S14: GateMARMUX, MARMUX=1, ADDR1=0, ADDR2=2, LD_REG, LD_CC, DRMUX=0 -> S18.
- JSR:
  - S4: GatePC, LD_REG, DRMUX=1.
  - From S4: IR[11]=1 -> S21, else -> S20.
  - S21: LD_PC, PCMUX=2, ADDR1=0, ADDR2=3 -> S18.
  - S20: LD_PC, PCMUX=2, ADDR1=1, ADDR2=0, SR1MUX=1 -> S18.
- JMP:
  - S12: same outputs as S20 -> S18.
- TRAP:
  - S15: GatePC, LD_REG, DRMUX=1 -> S47.
  - S47: GateMARMUX, MARMUX=0, LD_MAR -> S28.
  - S28: read -> S30.
  - S30: GateMDR, LD_PC, PCMUX=1 -> S18.
- Bus rule: at most one Gate* is high in any state.
- Reset mid-operation (including during a READY stall) abandons the instruction.

Decomposition:
- Package lc3_ctrl_pkg holds:
  - 6-bit state enum (values equal to the S-numbers).
  - Opcode constants.
  - All mux-select and ALUK encodings.
- Sub-module lc3_cc_ben: N/Z/P and BEN registers with their update logic.

Test Plan:
- Reset: hold RST=0 for 2 cycles, release -> state S18; N/Z/P=0/1/0; BEN=0; all outputs 0 during reset.
- Fetch stall: READY held low for 3 cycles in S33 -> CS=1, LD_MDR=1 held; after READY=1, state sequence S35 then S32.
- ADD: IR=0x1261 -> S1 with GateALU=1, LD_REG=1, LD_CC=1, ALUK=00; BUS=0x8000 -> N=1; BUS=0x0000 -> Z=1; BUS=0x0005 -> P=1.
- BR taken: with Z=1, IR=0x0403 -> BEN=1 after S32, then S0 -> S22 with PCMUX=2, ADDR2=2 -> S18.
- BR not taken: IR=0x0803 with Z=1 -> S0 -> S18.
- LDI: IR=0xA005 -> S10 -> S24 -> S26 -> S25 -> S27; reads stall on READY; final GateMDR=1, LD_REG=1.
- TRAP: IR=0xF025 -> S15 (DRMUX=1) -> S47 (MARMUX=0) -> S28 -> S30 (PCMUX=1) -> S18.
